// File: rtl/score_bcd_ctrl.sv
// score_bcd_ctrl: snake-game score keeper feeding the 7-segment display stage.
// Counts food-eaten events as a 2-digit packed BCD score, tracks the high
// score, and flags/blinks a new record after a game ends.
//
// Ports:
//   sys_clk       in   system clock, rising edge
//   sys_rst       in   asynchronous active-high reset
//   eat_in        in   food eaten (level); each rising edge adds one point
//   game_start    in   one-cycle pulse, start or restart a game
//   game_over     in   one-cycle pulse, snake died
//   game_clear    in   one-cycle pulse, return to idle
//   show_hi       in   1 = present high score on bcd_data
//   bcd_data      out  {tens,ones} of score, or high score when show_hi=1
//   start_signal  out  high while a game is running
//   clear_signal  out  one-cycle pulse after a clear or (re)start
//   new_record    out  last finished game set a new high score
//   blink         out  square wave while new_record, else 0
module score_bcd_ctrl #(
  parameter int unsigned SCORE_MAX     = 99,
  parameter int unsigned BLINK_CNT_MAX = 24_999_999
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       eat_in,
  input  logic       game_start,
  input  logic       game_over,
  input  logic       game_clear,
  input  logic       show_hi,
  output logic [7:0] bcd_data,
  output logic       start_signal,
  output logic       clear_signal,
  output logic       new_record,
  output logic       blink
);

  localparam int unsigned CNT_W =
    (BLINK_CNT_MAX > 0) ? $clog2(BLINK_CNT_MAX + 1) : 1;
  localparam logic [7:0] SCORE_SAT =
    {4'(SCORE_MAX / 10), 4'(SCORE_MAX % 10)};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t             state;
  logic [7:0]         score;
  logic [7:0]         hi;
  logic               eat_d;
  logic               eat_rise;
  logic [7:0]         score_inc;
  logic [7:0]         score_next;
  logic [CNT_W-1:0]   blink_cnt;

  assign eat_rise = eat_in & ~eat_d;

  // Saturating BCD increment; digits stay within 0..9.
  always_comb begin
    score_inc = score;
    if (score != SCORE_SAT) begin
      if (score[3:0] == 4'd9) begin
        score_inc = {score[7:4] + 4'd1, 4'd0};
      end else begin
        score_inc = {score[7:4], score[3:0] + 4'd1};
      end
    end
  end

  // Score after this cycle's eat; game_over compares against this value.
  assign score_next = eat_rise ? score_inc : score;

  // Game FSM, score and high-score registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state        <= IDLE;
      score        <= 8'h00;
      hi           <= 8'h00;
      eat_d        <= 1'b0;
      new_record   <= 1'b0;
      clear_signal <= 1'b0;
    end else begin
      eat_d        <= eat_in;
      clear_signal <= 1'b0;
      if (game_clear) begin
        state        <= IDLE;
        score        <= 8'h00;
        new_record   <= 1'b0;
        clear_signal <= 1'b1;
      end else if (game_start && state != RUN) begin
        state        <= RUN;
        score        <= 8'h00;
        new_record   <= 1'b0;
        clear_signal <= 1'b1;
      end else if (state == RUN) begin
        score <= score_next;
        if (game_over) begin
          state <= OVER;
          // Packed BCD orders like binary; a tie is not a record.
          if (score_next > hi) begin
            hi         <= score_next;
            new_record <= 1'b1;
          end
        end
      end
    end
  end

  // Blink half-period counter, idle and zeroed unless a record is flagged.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (!new_record) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (blink_cnt == CNT_W'(BLINK_CNT_MAX)) begin
      blink_cnt <= '0;
      blink     <= ~blink;
    end else begin
      blink_cnt <= blink_cnt + CNT_W'(1);
    end
  end

  assign bcd_data     = show_hi ? hi : score;
  assign start_signal = (state == RUN);

endmodule

// File: tb/tb_score_bcd_ctrl.sv
// Directed bench for score_bcd_ctrl: default-ceiling instance plus a
// SCORE_MAX=12 instance sharing the same stimulus.
module tb_score_bcd_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       eat_in;
  logic       game_start;
  logic       game_over;
  logic       game_clear;
  logic       show_hi;
  logic [7:0] bcd_data;
  logic       start_signal;
  logic       clear_signal;
  logic       new_record;
  logic       blink;
  logic [7:0] sat_bcd_data;
  logic       sat_start_signal;
  logic       sat_clear_signal;
  logic       sat_new_record;
  logic       sat_blink;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 sys_clk = ~sys_clk;

  score_bcd_ctrl #(.SCORE_MAX(99), .BLINK_CNT_MAX(3)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .eat_in       (eat_in),
    .game_start   (game_start),
    .game_over    (game_over),
    .game_clear   (game_clear),
    .show_hi      (show_hi),
    .bcd_data     (bcd_data),
    .start_signal (start_signal),
    .clear_signal (clear_signal),
    .new_record   (new_record),
    .blink        (blink)
  );

  score_bcd_ctrl #(.SCORE_MAX(12), .BLINK_CNT_MAX(3)) u_sat (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .eat_in       (eat_in),
    .game_start   (game_start),
    .game_over    (game_over),
    .game_clear   (game_clear),
    .show_hi      (show_hi),
    .bcd_data     (sat_bcd_data),
    .start_signal (sat_start_signal),
    .clear_signal (sat_clear_signal),
    .new_record   (sat_new_record),
    .blink        (sat_blink)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; leave 1 time unit so sampling is off the edge.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic pulse_start();
    game_start = 1'b1; tick(); game_start = 1'b0;
  endtask

  task automatic pulse_over();
    game_over = 1'b1; tick(); game_over = 1'b0;
  endtask

  task automatic eat_once();
    eat_in = 1'b1; tick(); tick();
    eat_in = 1'b0; tick(); tick();
  endtask

  task automatic eat_n(input int n);
    for (int i = 0; i < n; i++) eat_once();
  endtask

  logic [7:0] exp_bcd [10] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                               8'h06, 8'h07, 8'h08, 8'h09, 8'h10};

  initial begin
    sys_rst = 1'b1; eat_in = 1'b0; game_start = 1'b0; game_over = 1'b0;
    game_clear = 1'b0; show_hi = 1'b0;
    tick(); tick();
    sys_rst = 1'b0;
    tick();
    check("rst_bcd",   32'(bcd_data), 32'h00);
    check("rst_start", 32'(start_signal), 32'h0);
    check("rst_clear", 32'(clear_signal), 32'h0);
    check("rst_nrec",  32'(new_record), 32'h0);
    check("rst_blink", 32'(blink), 32'h0);

    // Start and carry from 09 to 10.
    pulse_start();
    check("start_run",   32'(start_signal), 32'h1);
    check("start_clear", 32'(clear_signal), 32'h1);
    tick();
    check("clear_1cyc",  32'(clear_signal), 32'h0);
    for (int i = 0; i < 10; i++) begin
      eat_once();
      check($sformatf("carry_%0d", i), 32'(bcd_data), 32'(exp_bcd[i]));
    end
    eat_in = 1'b1;
    repeat (20) tick();
    eat_in = 1'b0;
    tick();
    check("held_once", 32'(bcd_data), 32'h11);
    eat_n(6);
    check("score_17", 32'(bcd_data), 32'h17);

    // Reset mid-game.
    sys_rst = 1'b1;
    tick();
    check("mid_rst_bcd",   32'(bcd_data), 32'h00);
    check("mid_rst_start", 32'(start_signal), 32'h0);
    check("mid_rst_blink", 32'(blink), 32'h0);
    repeat (3) tick();
    check("hold_rst_bcd",   32'(bcd_data), 32'h00);
    check("hold_rst_start", 32'(start_signal), 32'h0);
    sys_rst = 1'b0;
    tick();

    // Record, blink and tie.
    pulse_start();
    tick();
    eat_n(5);
    pulse_over();
    check("rec_nrec",  32'(new_record), 32'h1);
    check("rec_state", 32'(start_signal), 32'h0);
    repeat (3) tick();
    check("blink_lo",  32'(blink), 32'h0);
    tick();
    check("blink_hi",  32'(blink), 32'h1);
    repeat (3) tick();
    check("blink_hold", 32'(blink), 32'h1);
    tick();
    check("blink_lo2", 32'(blink), 32'h0);
    show_hi = 1'b1; #1;
    check("rec_hi", 32'(bcd_data), 32'h05);
    show_hi = 1'b0;
    eat_once();
    check("over_eat_ign", 32'(bcd_data), 32'h05);
    pulse_start();
    check("restart_nrec",  32'(new_record), 32'h0);
    check("restart_clear", 32'(clear_signal), 32'h1);
    check("restart_bcd",   32'(bcd_data), 32'h00);
    tick();
    eat_n(5);
    pulse_over();
    check("tie_nrec",  32'(new_record), 32'h0);
    check("tie_blink", 32'(blink), 32'h0);
    show_hi = 1'b1; #1;
    check("tie_hi", 32'(bcd_data), 32'h05);
    show_hi = 1'b0;

    // Eat and game_over in the same cycle.
    pulse_start();
    tick();
    eat_n(9);
    check("pre_sim", 32'(bcd_data), 32'h09);
    eat_in = 1'b1; game_over = 1'b1;
    tick();
    eat_in = 1'b0; game_over = 1'b0;
    check("sim_state", 32'(start_signal), 32'h0);
    check("sim_score", 32'(bcd_data), 32'h10);
    check("sim_nrec",  32'(new_record), 32'h1);
    show_hi = 1'b1; #1;
    check("sim_hi", 32'(bcd_data), 32'h10);
    show_hi = 1'b0;

    // Clear from OVER.
    tick();
    game_clear = 1'b1; tick(); game_clear = 1'b0;
    check("clr_pulse", 32'(clear_signal), 32'h1);
    check("clr_bcd",   32'(bcd_data), 32'h00);
    check("clr_nrec",  32'(new_record), 32'h0);
    check("clr_state", 32'(start_signal), 32'h0);
    tick();
    check("clr_1cyc",  32'(clear_signal), 32'h0);
    check("clr_blink", 32'(blink), 32'h0);
    eat_n(3);
    check("idle_eat_ign", 32'(bcd_data), 32'h00);
    show_hi = 1'b1; #1;
    check("clr_hi_kept", 32'(bcd_data), 32'h10);
    show_hi = 1'b0;

    // Saturation at 12 on the small instance, 15 on the default one.
    pulse_start();
    tick();
    eat_n(15);
    check("sat_12",  32'(sat_bcd_data), 32'h12);
    check("nosat_15", 32'(bcd_data), 32'h15);
    pulse_start();
    check("run_start_ign", 32'(bcd_data), 32'h15);
    check("run_start_noclr", 32'(clear_signal), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
